// File: rtl/ssr_gearbox_pkg.sv
// Shared constants and types for the SSR6 -> SSR4 gearbox.
package ssr_gearbox_pkg;

  localparam int unsigned NPHASE  = 3;
  localparam int unsigned SSR_IN  = 6;
  localparam int unsigned SSR_OUT = 4;

  typedef logic [1:0] phase_t;

  localparam phase_t PH0     = 2'd0;
  localparam phase_t PH1     = 2'd1;
  localparam phase_t PH_LAST = phase_t'(NPHASE - 1);

  localparam int unsigned ERR_CE    = 0;
  localparam int unsigned ERR_PHASE = 1;

endpackage

// File: rtl/sat_trunc.sv
// Single-sample saturator from INBITS to OUTBITS (two's complement), purely combinational.
module sat_trunc #(
  parameter int unsigned INBITS  = 13,
  parameter int unsigned OUTBITS = 12
) (
  input  logic [INBITS-1:0]  din_i,
  output logic [OUTBITS-1:0] dout_o
);

  if (OUTBITS < INBITS) begin : g_sat
    logic [INBITS-OUTBITS:0] top_bits;
    logic                    ovf;

    // Overflow when the bits that must all match the sign disagree.
    assign top_bits = din_i[INBITS-1:OUTBITS-1];
    assign ovf      = !((&top_bits) || !(|top_bits));
    assign dout_o   = ovf ? {din_i[INBITS-1], {(OUTBITS-1){~din_i[INBITS-1]}}}
                          : din_i[OUTBITS-1:0];
  end else begin : g_pass
    assign dout_o = din_i[OUTBITS-1:0];
  end

endmodule

// File: rtl/ssr6_to_ssr4_gearbox.sv
// Re-packs 6-sample words arriving on phases 0/1 of a 3-clock frame into a
// continuous 4-sample-per-clock stream, with optional saturation and checking.
module ssr6_to_ssr4_gearbox
  import ssr_gearbox_pkg::*;
#(
  parameter int unsigned INBITS  = 13,
  parameter int unsigned OUTBITS = 12,
  parameter string       CHECK   = "TRUE"
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clk_phase_i,
  input  logic                        ce_i,
  input  logic [SSR_IN*INBITS-1:0]    dat_i,
  output logic [SSR_OUT*OUTBITS-1:0]  dat_o,
  output logic                        valid_o,
  output logic [1:0]                  err_o
);

  logic [SSR_IN-1:0][OUTBITS-1:0]  sat_c;
  phase_t                          ph_c, ph_q, ph_d;
  logic                            active_c;
  logic                            locked_q, locked_d;
  // Only the samples that outlive their input clock are held.
  logic [1:0][OUTBITS-1:0]         hold_a_q, hold_a_d;
  logic [3:0][OUTBITS-1:0]         hold_b_q, hold_b_d;
  logic [SSR_OUT-1:0][OUTBITS-1:0] dat_q, dat_d;
  logic                            valid_q, valid_d;
  logic [1:0]                      err_q;

  for (genvar i = 0; i < int'(SSR_IN); i++) begin : g_sat
    sat_trunc #(
      .INBITS  (INBITS),
      .OUTBITS (OUTBITS)
    ) u_sat (
      .din_i  (dat_i[i*INBITS +: INBITS]),
      .dout_o (sat_c[i])
    );
  end

  // Phase tracking, capture and output selection.
  always_comb begin
    ph_c     = clk_phase_i ? PH0 : ph_q;
    ph_d     = (ph_c == PH_LAST) ? PH0 : phase_t'(ph_c + 2'd1);
    active_c = locked_q | clk_phase_i;
    locked_d = locked_q | clk_phase_i;
    hold_a_d = hold_a_q;
    hold_b_d = hold_b_q;
    dat_d    = dat_q;
    valid_d  = valid_q;
    if (active_c) begin
      case (ph_c)
        PH0: begin
          hold_a_d = sat_c[5:4];
          dat_d    = sat_c[3:0];
          valid_d  = 1'b1;
        end
        PH1: begin
          hold_b_d = sat_c[5:2];
          dat_d    = {sat_c[1], sat_c[0], hold_a_q[1], hold_a_q[0]};
        end
        default: dat_d = hold_b_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q     <= PH0;
      locked_q <= 1'b0;
      hold_a_q <= '0;
      hold_b_q <= '0;
      dat_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      locked_q <= locked_d;
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
      dat_q    <= dat_d;
      valid_q  <= valid_d;
    end
  end

  if (CHECK == "TRUE") begin : g_chk
    logic [1:0] err_d;

    // Sticky CE-pattern and phase-slip flags, armed once locked.
    always_comb begin
      err_d = err_q;
      if (locked_q) begin
        if (clk_phase_i && (ph_q != PH0)) err_d[ERR_PHASE] = 1'b1;
        if (ce_i == (ph_c == PH_LAST))    err_d[ERR_CE]    = 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) err_q <= '0;
      else       err_q <= err_d;
    end
  end else begin : g_nochk
    assign err_q = '0;
  end

  assign dat_o   = dat_q;
  assign valid_o = valid_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_ssr6_to_ssr4_gearbox.sv
// Scoreboard bench for the SSR6 -> SSR4 gearbox, checked and unchecked builds side by side.
module tb_ssr6_to_ssr4_gearbox;

  localparam int unsigned INB  = 13;
  localparam int unsigned OUTB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst, clk_phase, ce, ce_nc;
  logic [5:0][INB-1:0]   dat;
  logic [4*OUTB-1:0]     dat_a, dat_b;
  logic                  valid_a, valid_b;
  logic [1:0]            err_a, err_b;

  ssr6_to_ssr4_gearbox #(.INBITS(INB), .OUTBITS(OUTB), .CHECK("TRUE")) dut (
    .clk_i(clk), .rst_i(rst), .clk_phase_i(clk_phase), .ce_i(ce), .dat_i(dat),
    .dat_o(dat_a), .valid_o(valid_a), .err_o(err_a)
  );

  ssr6_to_ssr4_gearbox #(.INBITS(INB), .OUTBITS(OUTB), .CHECK("FALSE")) dut_nc (
    .clk_i(clk), .rst_i(rst), .clk_phase_i(clk_phase), .ce_i(ce_nc), .dat_i(dat),
    .dat_o(dat_b), .valid_o(valid_b), .err_o(err_b)
  );

  typedef struct {
    int                due;
    logic [4*OUTB-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   s[12];
  int   base     = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [OUTB-1:0] sat12(input int v);
    if (v > 2047)  return 12'h7ff;
    if (v < -2048) return 12'h800;
    return 12'(v);
  endfunction

  function automatic void push(input int due, input int a, input int b, input int c, input int d);
    exp_t e;
    e.due  = due;
    e.data = {sat12(d), sat12(c), sat12(b), sat12(a)};
    sb.push_back(e);
  endfunction

  function automatic logic [5:0][INB-1:0] rand_word();
    logic [95:0] r;
    r = {$urandom(), $urandom(), $urandom()};
    return 78'(r);
  endfunction

  // One clock: drive inputs, then advance past the active edge.
  task automatic step(input logic p, input logic c, input logic [5:0][INB-1:0] d);
    clk_phase = p;
    ce        = c;
    ce_nc     = 1'($urandom_range(0, 1));
    dat       = d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One 3-clock frame; each output word is due one clock after its phase.
  task automatic frame(input bit drop_ce1, input bit rst_ph2);
    logic [5:0][INB-1:0] w0, w1;
    for (int i = 0; i < 6; i++) begin
      w0[i] = 13'(s[i]);
      w1[i] = 13'(s[6+i]);
    end
    push(cyc + 1, s[0], s[1], s[2], s[3]);
    step(1'b1, 1'b1, w0);
    push(cyc + 1, s[4], s[5], s[6], s[7]);
    step(1'b0, !drop_ce1, w1);
    if (rst_ph2) begin
      rst = 1'b1;
      step(1'b0, 1'b0, rand_word());
      check("rst_dat", 64'(dat_a), 64'(0));
      check("rst_valid", 64'(valid_a), 64'(0));
      check("rst_err", 64'(err_a), 64'(0));
      check("rst_valid_nc", 64'(valid_b), 64'(0));
      rst = 1'b0;
    end else begin
      push(cyc + 1, s[8], s[9], s[10], s[11]);
      step(1'b0, 1'b0, rand_word());
    end
  endtask

  task automatic ramp_frame(input bit drop_ce1, input bit rst_ph2);
    for (int i = 0; i < 12; i++) s[i] = base + i;
    base += 12;
    frame(drop_ce1, rst_ph2);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      exp_t e;
      e = sb.pop_front();
      check("dat", 64'(dat_a), 64'(e.data));
      check("dat_nc", 64'(dat_b), 64'(e.data));
      check("valid", 64'(valid_a), 64'(1));
    end
  end

  initial begin
    rst       = 1'b1;
    clk_phase = 1'b0;
    ce        = 1'b0;
    ce_nc     = 1'b0;
    dat       = '0;
    repeat (3) step(1'b0, 1'b0, '0);
    check("reset_dat", 64'(dat_a), 64'(0));
    check("reset_valid", 64'(valid_a), 64'(0));
    check("reset_err", 64'(err_a), 64'(0));
    rst = 1'b0;
    repeat (2) step(1'b0, 1'b0, rand_word());
    check("prelock_valid", 64'(valid_a), 64'(0));
    check("prelock_dat", 64'(dat_a), 64'(0));

    // Ramp stream.
    repeat (6) ramp_frame(1'b0, 1'b0);
    check("ramp_err", 64'(err_a), 64'(0));

    // Saturation boundaries, then random full-range samples.
    s = '{4095, -4096, 2047, -2048, 2048, -2049, 1, -1, 0, 4000, -4000, 2046};
    frame(1'b0, 1'b0);
    repeat (3) begin
      for (int i = 0; i < 12; i++) s[i] = int'($urandom_range(0, 8191)) - 4096;
      frame(1'b0, 1'b0);
    end
    check("sat_err", 64'(err_a), 64'(0));

    // CE dropped on one ph1.
    ramp_frame(1'b1, 1'b0);
    check("ce_err_set", 64'(err_a), 64'(2'b01));
    repeat (2) ramp_frame(1'b0, 1'b0);
    check("ce_err_sticky", 64'(err_a), 64'(2'b01));

    // Phase marker delayed by one clock.
    step(1'b0, 1'b1, rand_word());
    ramp_frame(1'b0, 1'b0);
    check("slip_err", 64'(err_a), 64'(2'b11));
    repeat (2) ramp_frame(1'b0, 1'b0);
    check("slip_err_sticky", 64'(err_a), 64'(2'b11));
    check("slip_valid", 64'(valid_a), 64'(1));

    // Reset on a ph2 clock, then re-lock.
    ramp_frame(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0, rand_word());
    check("relock_wait_valid", 64'(valid_a), 64'(0));
    repeat (3) ramp_frame(1'b0, 1'b0);
    check("relock_err", 64'(err_a), 64'(0));

    check("nc_err", 64'(err_b), 64'(0));
    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
